// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: memory-stage controller behind the EX/MEM pipeline register.
//
// It takes the registered EX/MEM fields and runs loads and stores on a
// handshaked data-memory bus. While an access is outstanding, it stalls the
// front of the pipeline. It also produces the MEM/WB register outputs.
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   i_wreg/i_m2reg/i_wmem          EX/MEM control (reg write, load, store)
//   i_alu, i_b, i_rn               EX/MEM address/ALU result, store data, dest reg
//   dm_req/dm_we/dm_addr/dm_wdata  data-memory request (held until ack/timeout)
//   dm_rdata, dm_ack               data-memory response (ack is a 1-cycle strobe)
//   o_stall                        combinational front-of-pipe freeze
//   o_wreg/o_m2reg/o_mo/o_alu/o_rn MEM/WB register
//   o_err                          sticky bus-timeout flag
module pipe_mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wreg,
    input  logic        i_m2reg,
    input  logic        i_wmem,
    input  logic [31:0] i_alu,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_rn,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        o_stall,
    output logic        o_wreg,
    output logic        o_m2reg,
    output logic [31:0] o_mo,
    output logic [31:0] o_alu,
    output logic [4:0]  o_rn,
    output logic        o_err
);

    localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            wb_wreg_q, wb_wreg_d;
    logic            wb_m2reg_q, wb_m2reg_d;
    logic [31:0]     wb_mo_q, wb_mo_d;
    logic [31:0]     wb_alu_q, wb_alu_d;
    logic [4:0]      wb_rn_q, wb_rn_d;

    logic memop;
    assign memop = i_m2reg | i_wmem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        // MEM/WB gets a bubble unless an instruction completes this cycle.
        wb_wreg_d  = 1'b0;
        wb_m2reg_d = 1'b0;
        wb_mo_d    = '0;
        wb_alu_d   = '0;
        wb_rn_d    = '0;
        o_stall    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (memop) begin
                    o_stall = 1'b1;
                    state_d = StBusy;
                    req_d   = 1'b1;
                    // A store takes priority when both load and store are set.
                    we_d    = i_wmem;
                    addr_d  = i_alu;
                    wdata_d = i_b;
                    cnt_d   = '0;
                end else begin
                    wb_wreg_d  = i_wreg;
                    wb_m2reg_d = i_m2reg;
                    wb_alu_d   = i_alu;
                    wb_rn_d    = i_rn;
                end
            end
            StBusy: begin
                o_stall = 1'b1;
                // An ack takes priority over the timeout in the same cycle.
                if (dm_ack) begin
                    rdata_d = we_q ? 32'h0 : dm_rdata;
                    req_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    rdata_d = 32'h0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // EX/MEM is still frozen, so its fields belong to this access.
                wb_wreg_d  = i_wreg;
                wb_m2reg_d = i_m2reg;
                wb_alu_d   = i_alu;
                wb_rn_d    = i_rn;
                wb_mo_d    = rdata_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wb_wreg_q  <= 1'b0;
            wb_m2reg_q <= 1'b0;
            wb_mo_q    <= '0;
            wb_alu_q   <= '0;
            wb_rn_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_m2reg_q <= wb_m2reg_d;
            wb_mo_q    <= wb_mo_d;
            wb_alu_q   <= wb_alu_d;
            wb_rn_q    <= wb_rn_d;
        end
    end

    assign dm_req   = req_q;
    assign dm_we    = we_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;
    assign o_wreg   = wb_wreg_q;
    assign o_m2reg  = wb_m2reg_q;
    assign o_mo     = wb_mo_q;
    assign o_alu    = wb_alu_q;
    assign o_rn     = wb_rn_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb_pipe_mem_stage: self-checking bench for pipe_mem_stage.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
module tb_pipe_mem_stage;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_wreg, i_m2reg, i_wmem;
    logic [31:0] i_alu, i_b;
    logic [4:0]  i_rn;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        o_stall, o_wreg, o_m2reg, o_err;
    logic [31:0] o_mo, o_alu;
    logic [4:0]  o_rn;

    int checks = 0;
    int errors = 0;
    bit model_err = 1'b0;

    pipe_mem_stage #(.MAX_WAIT(MW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_wreg   (i_wreg),
        .i_m2reg  (i_m2reg),
        .i_wmem   (i_wmem),
        .i_alu    (i_alu),
        .i_b      (i_b),
        .i_rn     (i_rn),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .o_stall  (o_stall),
        .o_wreg   (o_wreg),
        .o_m2reg  (o_m2reg),
        .o_mo     (o_mo),
        .o_alu    (o_alu),
        .o_rn     (o_rn),
        .o_err    (o_err)
    );

    always #5 clk = ~clk;

    // lat = BUSY cycle index carrying the ack; lat > MW means no ack (timeout).
    typedef struct {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
        int          lat;
        logic [31:0] rdata;
        int          exp_stall;
        logic [31:0] exp_mo;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wreg, input logic m2reg, input logic wmem,
                                input logic [31:0] alu, input logic [31:0] b,
                                input logic [4:0] rn, input int lat,
                                input logic [31:0] rdata, input int exp_stall,
                                input logic [31:0] exp_mo, input logic exp_err);
        vec_t v;
        v.wreg = wreg; v.m2reg = m2reg; v.wmem = wmem; v.alu = alu; v.b = b; v.rn = rn;
        v.lat = lat; v.rdata = rdata; v.exp_stall = exp_stall; v.exp_mo = exp_mo;
        v.exp_err = exp_err;
        return v;
    endfunction

    // Starts at a falling edge and returns at the falling edge after MEM/WB is loaded.
    task automatic run_op(input vec_t v, input string tag);
        int stalls;
        bit acked;
        stalls  = 0;
        i_wreg  = v.wreg;
        i_m2reg = v.m2reg;
        i_wmem  = v.wmem;
        i_alu   = v.alu;
        i_b     = v.b;
        i_rn    = v.rn;
        if (!(v.m2reg | v.wmem)) begin
            dm_ack   = 1'b1;  // spurious ack in IDLE must be ignored
            dm_rdata = 32'hFFFF_FFFF;
            #1;
            if (o_stall) stalls++;
            @(posedge clk);
            #1 dm_ack = 1'b0;
            @(negedge clk);
            #1;
            check({tag, " idle_req"}, {31'h0, dm_req}, 32'h0);
            check({tag, " idle_stall"}, {31'h0, o_stall}, 32'h0);
        end else begin
            #1;
            if (o_stall) stalls++;
            @(posedge clk);
            for (int n = 0; n <= MW; n++) begin
                @(negedge clk);
                #1;
                if (o_stall) stalls++;
                check({tag, " busy_req_we"}, {30'h0, dm_req, dm_we}, {30'h0, 1'b1, v.wmem});
                check({tag, " busy_addr"}, dm_addr, v.alu);
                check({tag, " busy_wdata"}, dm_wdata, v.b);
                check({tag, " busy_bubble"}, {o_alu | o_mo | {25'h0, o_rn, o_wreg, o_m2reg}},
                      32'h0);
                acked    = (n == v.lat);
                dm_ack   = acked;
                dm_rdata = v.rdata;
                @(posedge clk);
                #1;
                dm_ack   = 1'b0;
                dm_rdata = $urandom;
                if (acked) break;
            end
            @(negedge clk);
            #1;
            if (o_stall) stalls++;
            check({tag, " done_req"}, {31'h0, dm_req}, 32'h0);
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
        check({tag, " wb_ctl"}, {30'h0, o_wreg, o_m2reg}, {30'h0, v.wreg, v.m2reg});
        check({tag, " wb_alu"}, o_alu, v.alu);
        check({tag, " wb_rn"}, {27'h0, o_rn}, {27'h0, v.rn});
        check({tag, " wb_mo"}, o_mo, v.exp_mo);
        check({tag, " err"}, {31'h0, o_err}, {31'h0, v.exp_err});
    endtask

    // Reference model: outcome of one instruction from the memory-stage rules.
    function automatic vec_t model_op(input logic wreg, input int kind, input logic [31:0] alu,
                                      input logic [31:0] b, input logic [4:0] rn,
                                      input int lat, input logic [31:0] rdata);
        vec_t v;
        bit memop, timeout;
        v = mk(wreg, kind == 1 || kind == 3, kind == 2 || kind == 3, alu, b, rn, lat, rdata,
               0, 32'h0, 1'b0);
        memop   = (kind != 0);
        timeout = memop && (lat > MW);
        v.exp_stall = !memop ? 0 : (timeout ? MW + 2 : lat + 2);
        v.exp_mo    = (!memop || v.wmem || timeout) ? 32'h0 : rdata;
        if (timeout) model_err = 1'b1;
        v.exp_err = model_err;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   kind;
        tbl[0] = mk(1, 0, 0, 32'h12, 32'h0, 5'd3, 0, 32'h0, 0, 32'h0, 0);
        tbl[1] = mk(1, 1, 0, 32'h40, 32'h0, 5'd7, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 0);
        tbl[2] = mk(0, 0, 1, 32'h80, 32'h55, 5'd0, 3, 32'h1234, 5, 32'h0, 0);
        tbl[3] = mk(1, 1, 1, 32'h90, 32'h77, 5'd4, 1, 32'hAAAA, 3, 32'h0, 0);
        tbl[4] = mk(1, 1, 0, 32'hA0, 32'h0, 5'd5, 15, 32'hCAFEF00D, 17, 32'hCAFEF00D, 0);
        tbl[5] = mk(1, 1, 0, 32'hB0, 32'h0, 5'd6, 99, 32'h1111, 17, 32'h0, 1);
        tbl[6] = mk(1, 1, 0, 32'hC0, 32'h0, 5'd8, 2, 32'h0BADF00D, 4, 32'h0BADF00D, 1);

        rst = 1'b0;
        {i_wreg, i_m2reg, i_wmem, dm_ack} = '0;
        i_alu = '0; i_b = '0; i_rn = '0; dm_rdata = '0;

        // Reset held with random inputs: everything registered stays at zero.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            {i_wreg, i_m2reg, i_wmem, dm_ack} = 4'($urandom);
            i_alu = $urandom; i_b = $urandom; i_rn = 5'($urandom); dm_rdata = $urandom;
            #1;
            check("rst_ctl", {26'h0, dm_req, dm_we, o_wreg, o_m2reg, o_err, 1'b0}, 32'h0);
            check("rst_data", dm_addr | dm_wdata | o_mo | o_alu | {27'h0, o_rn}, 32'h0);
            check("rst_stall", {31'h0, o_stall}, {31'h0, i_m2reg | i_wmem});
        end
        @(negedge clk);
        {i_wreg, i_m2reg, i_wmem, dm_ack} = '0;
        #1 rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));
        model_err = 1'b1;

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 3);
            v = model_op(1'($urandom), kind, $urandom, $urandom, 5'($urandom),
                         $urandom_range(0, MW + 3), $urandom);
            run_op(v, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of an access aborts it at once.
        i_wreg = 1'b1; i_m2reg = 1'b1; i_wmem = 1'b0; i_alu = 32'h100; i_rn = 5'd9;
        @(posedge clk);
        @(negedge clk);
        #1 check("midrst_pre_req", {31'h0, dm_req}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_req", {31'h0, dm_req}, 32'h0);
        check("midrst_wb", {29'h0, o_wreg, o_m2reg, o_err}, 32'h0);
        check("midrst_addr", dm_addr, 32'h0);
        {i_wreg, i_m2reg, i_wmem} = '0;
        #1 check("midrst_stall", {31'h0, o_stall}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        model_err = 1'b0;
        @(negedge clk);
        run_op(model_op(1'b1, 1, 32'h200, 32'h0, 5'd10, 1, 32'h600D), "post_rst_load");
        run_op(model_op(1'b0, 2, 32'h204, 32'h99, 5'd0, 0, 32'h0), "post_rst_store");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
